// File: rtl/imm_encoder.sv
// imm_encoder
//   Scatters a 32-bit two's-complement immediate into the I/S/B/U/J bit
//   positions of a prebuilt RISC-V instruction word. The result is held in a
//   single valid/ready output register.
//
//   Optional feature macro: IMM_RANGE_CHECK_EN
//     defined   : immediates that do not fit the format, and illegal format
//                 codes, raise range_err and are counted in err_count.
//     undefined : range_err and err_count are tied to 0.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready request handshake (in_ready = !out_valid || out_ready)
//   imm_type          000 I, 001 S, 010 B, 011 U, 100 J, others illegal
//   imm               immediate (byte offset for B/J)
//   base_instr        instruction with the non-immediate fields filled in
//   out_valid/out_ready result handshake
//   instr, range_err  registered result; range_err qualified by out_valid
//   enc_count         accepted requests, saturating
//   err_count         accepted requests with range_err, saturating
module imm_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  imm_type,
  input  logic [31:0] imm,
  input  logic [31:0] base_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic        range_err,
  output logic [15:0] enc_count,
  output logic [15:0] err_count
);

  typedef enum logic [2:0] {
    FMT_I = 3'd0,
    FMT_S = 3'd1,
    FMT_B = 3'd2,
    FMT_U = 3'd3,
    FMT_J = 3'd4
  } imm_fmt_e;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } enc_rsp_t;

  enc_rsp_t nxt;
  logic     accept;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Encoding: start from base_instr and overwrite only the immediate slots.
  // Out-of-range immediates are simply truncated into those slots.
  always_comb begin
    nxt.instr = base_instr;
    case (imm_fmt_e'(imm_type))
      FMT_I: nxt.instr[31:20] = imm[11:0];
      FMT_S: begin
        nxt.instr[31:25] = imm[11:5];
        nxt.instr[11:7]  = imm[4:0];
      end
      FMT_B: begin
        nxt.instr[31]    = imm[12];
        nxt.instr[30:25] = imm[10:5];
        nxt.instr[11:8]  = imm[4:1];
        nxt.instr[7]     = imm[11];
      end
      FMT_U: nxt.instr[31:12] = imm[31:12];
      FMT_J: begin
        nxt.instr[31]    = imm[20];
        nxt.instr[30:21] = imm[10:1];
        nxt.instr[20]    = imm[11];
        nxt.instr[19:12] = imm[19:12];
      end
      default: nxt.instr = base_instr;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  // A value fits an N-bit signed field when every bit from N-1 upward is a
  // copy of the sign, i.e. the slice is all zeros or all ones.
  always_comb begin
    nxt.err = 1'b1;
    case (imm_fmt_e'(imm_type))
      FMT_I, FMT_S: nxt.err = !((&imm[31:11]) || !(|imm[31:11]));
      FMT_B:        nxt.err = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
      FMT_U:        nxt.err = |imm[11:0];
      FMT_J:        nxt.err = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
      default:      nxt.err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      err_count <= '0;
    else if (accept && nxt.err && err_count != 16'hFFFF)
      err_count <= err_count + 16'd1;
  end
`else
  assign nxt.err   = 1'b0;
  assign err_count = '0;
`endif

  // Output register. A simultaneous drain and accept simply overwrites the
  // held result, so out_valid stays high.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      instr     <= '0;
      range_err <= 1'b0;
      enc_count <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      instr     <= nxt.instr;
      range_err <= nxt.err;
      if (enc_count != 16'hFFFF)
        enc_count <= enc_count + 16'd1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder with a transaction-level reference model.
module tb_imm_encoder;

`ifdef IMM_RANGE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, range_err;
  logic [2:0]  imm_type;
  logic [31:0] imm, base_instr, instr;
  logic [15:0] enc_count, err_count;

  imm_encoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .imm_type(imm_type), .imm(imm), .base_instr(base_instr),
    .out_valid(out_valid), .out_ready(out_ready), .instr(instr),
    .range_err(range_err), .enc_count(enc_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference encoding from the field layout, with legality expressed as
  // signed numeric ranges and alignment.
  function automatic void ref_enc(input logic [2:0] t, input logic [31:0] v,
                                  input logic [31:0] base,
                                  output logic [31:0] res, output logic err);
    logic [31:0] field, mask;
    int          s;
    bit          ok;
    s = int'(v);
    field = 0; mask = 0; ok = 1'b0;
    case (t)
      3'd0: begin field = v << 20; mask = 32'hFFF0_0000; ok = (s >= -2048 && s <= 2047); end
      3'd1: begin
        field = (((v >> 5) & 32'h7F) << 25) | ((v & 32'h1F) << 7);
        mask = 32'hFE00_0F80; ok = (s >= -2048 && s <= 2047);
      end
      3'd2: begin
        field = (((v >> 12) & 1) << 31) | (((v >> 5) & 32'h3F) << 25) |
                (((v >> 1) & 32'hF) << 8) | (((v >> 11) & 1) << 7);
        mask = 32'hFE00_0F80; ok = (s >= -4096 && s <= 4094 && (s % 2) == 0);
      end
      3'd3: begin field = v & 32'hFFFF_F000; mask = 32'hFFFF_F000; ok = ((v % 4096) == 0); end
      3'd4: begin
        field = (((v >> 20) & 1) << 31) | (((v >> 1) & 32'h3FF) << 21) |
                (((v >> 11) & 1) << 20) | (v & 32'h000F_F000);
        mask = 32'hFFFF_F000; ok = (s >= -1048576 && s <= 1048574 && (s % 2) == 0);
      end
      default: ok = 1'b0;
    endcase
    res = (base & ~mask) | field;
    err = CHK && !ok;
  endfunction

  // Transaction model of the output register and counters.
  logic        m_valid, m_err;
  logic [31:0] m_instr;
  int          m_enc, m_errc;

  always @(posedge clk) begin
    logic [31:0] r;
    logic        e;
    if (rst) begin
      m_valid <= 1'b0; m_instr <= 0; m_err <= 1'b0; m_enc <= 0; m_errc <= 0;
    end else if (in_valid && (!m_valid || out_ready)) begin
      ref_enc(imm_type, imm, base_instr, r, e);
      m_valid <= 1'b1; m_instr <= r; m_err <= e;
      m_enc  <= (m_enc  < 65535) ? m_enc + 1 : 65535;
      m_errc <= (e && m_errc < 65535) ? m_errc + 1 : m_errc;
    end else if (out_ready) begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("cmp in_ready", in_ready, !m_valid || out_ready);
      chk("cmp out_valid", out_valid, m_valid);
      chk("cmp enc_count", enc_count, m_enc);
      chk("cmp err_count", err_count, m_errc);
      if (m_valid) begin
        chk("cmp instr", instr, m_instr);
        chk("cmp range_err", range_err, m_err);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] t, input logic [31:0] v, input logic [31:0] b);
    in_valid = 1'b1; imm_type = t; imm = v; base_instr = b;
  endtask

  // Boundary vectors; expectations come from the model.
  logic [2:0]  vt [19] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2,
                           3'd2, 3'd3, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd5, 3'd6};
  logic [31:0] vi [19] = '{32'd2047, 32'hFFFF_F800, 32'd2048, 32'hFFFF_F7FF, 32'd0,
                           32'hFFFF_F800, 32'd2048, 32'd4094, 32'hFFFF_F000, 32'd4096,
                           32'd7, 32'hFFFF_F000, 32'd1, 32'h000F_FFFE, 32'hFFF0_0000,
                           32'h0010_0000, 32'hFFFF_FFFE, 32'h123, 32'd0};
  logic [31:0] vb [19] = '{32'h93, 32'h93, 32'h93, 32'h93, 32'hFFFF_FFFF,
                           32'h2023, 32'hFFFF_FFFF, 32'h1063, 32'hFFFF_FFFF, 32'h63,
                           32'h63, 32'hFFFF_FFFF, 32'h37, 32'h6F, 32'hFFFF_FFFF,
                           32'h6F, 32'h6F, 32'h1234_5678, 32'hFFFF_FFFF};

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit done;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    imm_type = 3'd0; imm = 0; base_instr = 0;
    step(); step();
    started = 1'b1;
    chk("reset out_valid", out_valid, 1'b0);
    chk("reset instr", instr, 32'h0);
    chk("reset range_err", range_err, 1'b0);
    chk("reset enc_count", enc_count, 16'd0);
    chk("reset err_count", err_count, 16'd0);
    chk("reset in_ready", in_ready, 1'b1);
    rst = 1'b0; out_ready = 1'b1;

    // I-type
    drive(3'd0, 32'hFFFF_F800, 32'h13); step();
    chk("I instr", instr, 32'h8000_0013);
    chk("I range_err", range_err, 1'b0);
    chk("I enc_count", enc_count, 16'd1);

    // B then U back-to-back
    drive(3'd2, 32'hFFFF_F000, 32'h63); step();
    chk("B instr", instr, 32'h8000_0063);
    chk("B range_err", range_err, 1'b0);
    drive(3'd3, 32'h1234_5000, 32'h37); step();
    chk("U instr", instr, 32'h1234_5037);
    chk("U out_valid", out_valid, 1'b1);

    // J misaligned
    drive(3'd4, 32'h0000_0801, 32'h6F); step();
    chk("J instr", instr, 32'h0010_006F);
    chk("J range_err", range_err, CHK);
    chk("J err_count", err_count, CHK ? 16'd1 : 16'd0);

    // Backpressure
    drive(3'd1, 32'h7FF, 32'h2023); step();
    out_ready = 1'b0;
    drive(3'd0, 32'd5, 32'h13);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp in_ready", in_ready, 1'b0);
      step();
      chk("bp instr", instr, 32'h7E00_2FA3);
      chk("bp enc_count", enc_count, 16'd5);
    end
    out_ready = 1'b1; step();
    chk("bp release instr", instr, 32'h0050_0013);
    chk("bp release enc_count", enc_count, 16'd6);

    // Illegal type
    drive(3'd7, 32'h0, 32'hDEAD_BEEF); step();
    chk("illegal instr", instr, 32'hDEAD_BEEF);
    chk("illegal range_err", range_err, CHK);
    in_valid = 1'b0; step();

    // Reset with a result held under backpressure
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 5; i++) begin drive(3'd0, i, 32'h13); step(); end
    in_valid = 1'b0; out_ready = 1'b0; step();
    chk("pre-rst enc_count", enc_count, 16'd5);
    chk("pre-rst out_valid", out_valid, 1'b1);
    rst = 1'b1; drive(3'd0, 32'd9, 32'h13); step();
    chk("rst out_valid", out_valid, 1'b0);
    chk("rst instr", instr, 32'h0);
    chk("rst enc_count", enc_count, 16'd0);
    chk("rst err_count", err_count, 16'd0);
    chk("rst in_ready", in_ready, 1'b1);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; step();

    // Boundary table with occasional stalls
    for (int i = 0; i < 19; i++) begin
      out_ready = (i % 3) != 2;
      drive(vt[i], vi[i], vb[i]);
      done = 1'b0;
      for (int k = 0; k < 8 && !done; k++) begin
        #1;
        if (in_ready) done = 1'b1;
        else out_ready = 1'b1;
        step();
      end
      if (!done) chk("table accept", 1'b0, 1'b1);
    end
    in_valid = 1'b0; out_ready = 1'b1; step();

    // Saturation of enc_count
    rst = 1'b1; step(); rst = 1'b0;
    drive(3'd3, 32'h1000, 32'h37);
    for (int i = 0; i < 65540; i++) step();
    in_valid = 1'b0; step();
    chk("sat enc_count", enc_count, 16'hFFFF);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
